// File: rtl/csc_row_seq.sv
// csc_row_seq: row sequencer for the circulant CSC matrix store.
// Takes one first-row descriptor (1..4 complex nonzeros and their columns) and
// streams all MAT_RANK*nnz nonzeros as (row, col, value) beats. Row r uses the
// first-row columns rotated by r.
// Optional feature macro: CSC_SEQ_PERF_EN adds the stall_cnt output.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_vld/cfg_rdy                 descriptor handshake
//   cfg_nnz, cfg_col, cfg_val_i/r   descriptor payload (slot k at k*width)
//   cfg_err                         1-cycle pulse on accepted illegal nnz
//   out_vld/out_rdy                 beat handshake
//   out_row, out_col, out_val_i/r   beat payload
//   out_last_row, out_last          last nonzero of row / of matrix
//   stall_cnt                       (CSC_SEQ_PERF_EN) out_vld&!out_rdy cycles
//   busy                            high while streaming
module csc_row_seq #(
    parameter  int unsigned MAT_RANK = 256,
    localparam int unsigned INDEX_W  = $clog2(MAT_RANK)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_vld,
    output logic                   cfg_rdy,
    input  logic [2:0]             cfg_nnz,
    input  logic [4*INDEX_W-1:0]   cfg_col,
    input  logic [127:0]           cfg_val_i,
    input  logic [127:0]           cfg_val_r,
    output logic                   cfg_err,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [INDEX_W-1:0]     out_row,
    output logic [INDEX_W-1:0]     out_col,
    output logic [31:0]            out_val_i,
    output logic [31:0]            out_val_r,
    output logic                   out_last_row,
    output logic                   out_last,
`ifdef CSC_SEQ_PERF_EN
    output logic [31:0]            stall_cnt,
`endif
    output logic                   busy
);

    localparam logic [INDEX_W-1:0] ROW_LAST = INDEX_W'(MAT_RANK - 1);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    state_t                    r_state, w_state_nxt;
    logic [2:0]                r_nnz, w_nnz_nxt;
    logic [3:0][INDEX_W-1:0]   r_col, w_col_nxt;
    logic [3:0][31:0]          r_val_i, w_val_i_nxt;
    logic [3:0][31:0]          r_val_r, w_val_r_nxt;
    logic [1:0]                r_k, w_k_nxt;
    logic                      r_cfg_rdy, w_cfg_rdy_nxt;
    logic                      r_cfg_err, w_cfg_err_nxt;
    logic                      r_out_vld, w_out_vld_nxt;
    logic [INDEX_W-1:0]        r_out_row, w_out_row_nxt;
    logic [INDEX_W-1:0]        r_out_col, w_out_col_nxt;
    logic [31:0]               r_out_vi, w_out_vi_nxt;
    logic [31:0]               r_out_vr, w_out_vr_nxt;
    logic                      r_out_last_row, w_out_last_row_nxt;
    logic                      r_out_last, w_out_last_nxt;
    logic                      r_busy, w_busy_nxt;

    logic [3:0][INDEX_W-1:0]   w_cfg_col;
    logic [3:0][31:0]          w_cfg_vi;
    logic [3:0][31:0]          w_cfg_vr;
    logic [1:0]                w_kmax;
    logic                      w_nnz_ok;
    logic                      w_cfg_fire;

    assign w_cfg_col  = cfg_col;
    assign w_cfg_vi   = cfg_val_i;
    assign w_cfg_vr   = cfg_val_r;
    assign w_kmax     = 2'(r_nnz - 3'd1);
    assign w_nnz_ok   = (cfg_nnz != 3'd0) && (cfg_nnz <= 3'd4);
    assign w_cfg_fire = cfg_vld && r_cfg_rdy;

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        w_state_nxt        = r_state;
        w_nnz_nxt          = r_nnz;
        w_col_nxt          = r_col;
        w_val_i_nxt        = r_val_i;
        w_val_r_nxt        = r_val_r;
        w_k_nxt            = r_k;
        w_cfg_rdy_nxt      = r_cfg_rdy;
        w_cfg_err_nxt      = 1'b0;
        w_out_vld_nxt      = r_out_vld;
        w_out_row_nxt      = r_out_row;
        w_out_col_nxt      = r_out_col;
        w_out_vi_nxt       = r_out_vi;
        w_out_vr_nxt       = r_out_vr;
        w_out_last_row_nxt = r_out_last_row;
        w_out_last_nxt     = r_out_last;
        w_busy_nxt         = r_busy;

        case (r_state)
            ST_IDLE: begin
                if (w_cfg_fire) begin
                    w_nnz_nxt   = cfg_nnz;
                    w_col_nxt   = w_cfg_col;
                    w_val_i_nxt = w_cfg_vi;
                    w_val_r_nxt = w_cfg_vr;
                    if (w_nnz_ok) begin
                        // Preload beat (row 0, slot 0) so it is valid next cycle.
                        w_state_nxt        = ST_EMIT;
                        w_k_nxt            = 2'd0;
                        w_cfg_rdy_nxt      = 1'b0;
                        w_busy_nxt         = 1'b1;
                        w_out_vld_nxt      = 1'b1;
                        w_out_row_nxt      = '0;
                        w_out_col_nxt      = w_cfg_col[0];
                        w_out_vi_nxt       = w_cfg_vi[0];
                        w_out_vr_nxt       = w_cfg_vr[0];
                        w_out_last_row_nxt = (cfg_nnz == 3'd1);
                        w_out_last_nxt     = 1'b0;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_rdy) begin
                    if (r_out_last) begin
                        w_state_nxt        = ST_IDLE;
                        w_cfg_rdy_nxt      = 1'b1;
                        w_busy_nxt         = 1'b0;
                        w_out_vld_nxt      = 1'b0;
                        w_out_last_row_nxt = 1'b0;
                        w_out_last_nxt     = 1'b0;
                    end else begin
                        if (r_k == w_kmax) begin
                            w_k_nxt       = 2'd0;
                            w_out_row_nxt = r_out_row + INDEX_W'(1);
                        end else begin
                            w_k_nxt       = r_k + 2'd1;
                        end
                        // Rotation relies on natural INDEX_W wrap for mod MAT_RANK.
                        w_out_col_nxt      = r_col[w_k_nxt] + w_out_row_nxt;
                        w_out_vi_nxt       = r_val_i[w_k_nxt];
                        w_out_vr_nxt       = r_val_r[w_k_nxt];
                        w_out_last_row_nxt = (w_k_nxt == w_kmax);
                        w_out_last_nxt     = (w_k_nxt == w_kmax) && (w_out_row_nxt == ROW_LAST);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_nnz          <= '0;
            r_col          <= '0;
            r_val_i        <= '0;
            r_val_r        <= '0;
            r_k            <= '0;
            r_cfg_rdy      <= 1'b1;
            r_cfg_err      <= 1'b0;
            r_out_vld      <= 1'b0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_out_vi       <= '0;
            r_out_vr       <= '0;
            r_out_last_row <= 1'b0;
            r_out_last     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_nnz          <= w_nnz_nxt;
            r_col          <= w_col_nxt;
            r_val_i        <= w_val_i_nxt;
            r_val_r        <= w_val_r_nxt;
            r_k            <= w_k_nxt;
            r_cfg_rdy      <= w_cfg_rdy_nxt;
            r_cfg_err      <= w_cfg_err_nxt;
            r_out_vld      <= w_out_vld_nxt;
            r_out_row      <= w_out_row_nxt;
            r_out_col      <= w_out_col_nxt;
            r_out_vi       <= w_out_vi_nxt;
            r_out_vr       <= w_out_vr_nxt;
            r_out_last_row <= w_out_last_row_nxt;
            r_out_last     <= w_out_last_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

`ifdef CSC_SEQ_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating stall counter, restarted by every accepted descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_cfg_fire) begin
            r_stall_cnt <= '0;
        end else if (r_out_vld && !out_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign cfg_rdy      = r_cfg_rdy;
    assign cfg_err      = r_cfg_err;
    assign out_vld      = r_out_vld;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign out_val_i    = r_out_vi;
    assign out_val_r    = r_out_vr;
    assign out_last_row = r_out_last_row;
    assign out_last     = r_out_last;
    assign busy         = r_busy;

endmodule

// File: tb/tb_csc_row_seq.sv
// Directed bench for csc_row_seq at MAT_RANK=8. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_csc_row_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_vld;
    logic                 cfg_rdy;
    logic [2:0]           cfg_nnz;
    logic [3:0][IW-1:0]   cfg_col;
    logic [3:0][31:0]     cfg_val_i;
    logic [3:0][31:0]     cfg_val_r;
    logic                 cfg_err;
    logic                 out_vld;
    logic                 out_rdy;
    logic [IW-1:0]        out_row;
    logic [IW-1:0]        out_col;
    logic [31:0]          out_val_i;
    logic [31:0]          out_val_r;
    logic                 out_last_row;
    logic                 out_last;
    logic                 busy;
`ifdef CSC_SEQ_PERF_EN
    logic [31:0]          stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference descriptor for the stream currently expected.
    int          m_nnz;
    logic [2:0]  m_col [4];
    logic [31:0] m_vi  [4];
    logic [31:0] m_vr  [4];

    csc_row_seq #(.MAT_RANK(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_vld      (cfg_vld),
        .cfg_rdy      (cfg_rdy),
        .cfg_nnz      (cfg_nnz),
        .cfg_col      (cfg_col),
        .cfg_val_i    (cfg_val_i),
        .cfg_val_r    (cfg_val_r),
        .cfg_err      (cfg_err),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_val_i    (out_val_i),
        .out_val_r    (out_val_r),
        .out_last_row (out_last_row),
        .out_last     (out_last),
`ifdef CSC_SEQ_PERF_EN
        .stall_cnt    (stall_cnt),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {vld,row,col,val_i,val_r,last_row,last} for beat b of the stream.
    function automatic logic [72:0] exp_beat(input int b);
        int         row;
        int         k;
        logic [2:0] col;
        logic       lr;
        logic       l;
        row = b / m_nnz;
        k   = b % m_nnz;
        col = 3'((int'(m_col[k]) + row) % 8);
        lr  = (k == m_nnz - 1);
        l   = lr && (row == 7);
        return {1'b1, 3'(row), col, m_vi[k], m_vr[k], lr, l};
    endfunction

    function automatic logic [72:0] act_beat();
        return {out_vld, out_row, out_col, out_val_i, out_val_r, out_last_row, out_last};
    endfunction

    // Drive the reference descriptor onto the cfg port with cfg_vld high.
    task automatic drive_cfg(input int nnz);
        m_nnz   = nnz;
        cfg_nnz = 3'(nnz);
        for (int k = 0; k < 4; k++) begin
            cfg_col[k]   = m_col[k];
            cfg_val_i[k] = m_vi[k];
            cfg_val_r[k] = m_vr[k];
        end
        cfg_vld = 1'b1;
    endtask

    task automatic set_desc4();
        m_col[0] = 3'd1; m_col[1] = 3'd3; m_col[2] = 3'd5; m_col[3] = 3'd7;
        for (int k = 0; k < 4; k++) begin
            m_vi[k] = 32'(100 + k);
            m_vr[k] = 32'(-(k + 1) * 1000);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_vld = 1'b0; cfg_nnz = '0; cfg_col = '0;
        cfg_val_i = '0; cfg_val_r = '0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cfg_rdy, cfg_err, out_vld, busy} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {cfg_rdy, cfg_err, out_vld, busy});
        end
        n_checks++;
        if (act_beat() !== 73'd0) begin
            n_errors++;
            $display("FAIL reset_beat: got %h expected 0", act_beat());
        end
`ifdef CSC_SEQ_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_rate();
        set_desc4();
        out_rdy = 1'b1;
        drive_cfg(4);
        @(negedge clk);
        cfg_vld = 1'b0;
        n_checks++;
        if ({out_vld, busy, cfg_rdy} !== 3'b110) begin
            n_errors++;
            $display("FAIL full_latency: got %b expected 110", {out_vld, busy, cfg_rdy});
        end
        for (int b = 0; b < 32; b++) begin
            n_checks++;
            if (act_beat() !== exp_beat(b)) begin
                n_errors++;
                $display("FAIL full_beat%0d: got %h expected %h", b, act_beat(), exp_beat(b));
            end
            if (b == 4 || b == 7) begin
                n_checks++;
                if (out_col !== ((b == 4) ? 3'd2 : 3'd0)) begin
                    n_errors++;
                    $display("FAIL full_row1_col b%0d: got %0d expected %0d", b, out_col, (b == 4) ? 2 : 0);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_vld, busy, cfg_rdy} !== 3'b001) begin
            n_errors++;
            $display("FAIL full_end: got %b expected 001", {out_vld, busy, cfg_rdy});
        end
    endtask

    task automatic test_two_slot();
        m_col[0] = 3'd2; m_col[1] = 3'd6; m_col[2] = 3'd0; m_col[3] = 3'd0;
        m_vi[0] = 32'd5;           m_vr[0] = 32'hFFFF_FFFD;
        m_vi[1] = 32'hFFFF_FFFF;   m_vr[1] = 32'd7;
        m_vi[2] = '0; m_vr[2] = '0; m_vi[3] = '0; m_vr[3] = '0;
        out_rdy = 1'b1;
        drive_cfg(2);
        @(negedge clk);
        cfg_vld = 1'b0;
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (act_beat() !== exp_beat(b)) begin
                n_errors++;
                $display("FAIL two_beat%0d: got %h expected %h", b, act_beat(), exp_beat(b));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_vld, cfg_rdy} !== 2'b01) begin
            n_errors++;
            $display("FAIL two_end: got %b expected 01", {out_vld, cfg_rdy});
        end
    endtask

    task automatic test_stall();
        set_desc4();
        out_rdy = 1'b1;
        drive_cfg(4);
        @(negedge clk);
        cfg_vld = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (b == 17) begin
                out_rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    n_checks++;
                    if (act_beat() !== exp_beat(17)) begin
                        n_errors++;
                        $display("FAIL stall_hold%0d: got %h expected %h", s, act_beat(), exp_beat(17));
                    end
                end
                out_rdy = 1'b1;
            end
            n_checks++;
            if (act_beat() !== exp_beat(b)) begin
                n_errors++;
                $display("FAIL stall_beat%0d: got %h expected %h", b, act_beat(), exp_beat(b));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_vld, cfg_rdy} !== 2'b01) begin
            n_errors++;
            $display("FAIL stall_end: got %b expected 01", {out_vld, cfg_rdy});
        end
`ifdef CSC_SEQ_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_cfg_during_emit();
        m_col[0] = 3'd4; m_vi[0] = 32'h1234_5678; m_vr[0] = 32'h8765_4321;
        out_rdy = 1'b1;
        drive_cfg(1);
        @(negedge clk);
        // Keep offering a different descriptor while the stream runs.
        cfg_nnz = 3'd3;
        for (int k = 0; k < 4; k++) begin
            cfg_col[k]   = 3'(k * 3);
            cfg_val_i[k] = 32'(7 * k + 1);
            cfg_val_r[k] = 32'(-9 * k - 2);
        end
        for (int b = 0; b < 8; b++) begin
            n_checks++;
            if ({cfg_rdy, act_beat()} !== {1'b0, exp_beat(b)}) begin
                n_errors++;
                $display("FAIL busy_beat%0d: got %h expected %h", b, {cfg_rdy, act_beat()}, {1'b0, exp_beat(b)});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_vld, cfg_rdy} !== 2'b01) begin
            n_errors++;
            $display("FAIL busy_end: got %b expected 01", {out_vld, cfg_rdy});
        end
        for (int k = 0; k < 4; k++) begin
            m_col[k] = 3'(k * 3);
            m_vi[k]  = 32'(7 * k + 1);
            m_vr[k]  = 32'(-9 * k - 2);
        end
        m_nnz = 3;
        @(negedge clk);
        cfg_vld = 1'b0;
        for (int b = 0; b < 24; b++) begin
            n_checks++;
            if (act_beat() !== exp_beat(b)) begin
                n_errors++;
                $display("FAIL busy_new_beat%0d: got %h expected %h", b, act_beat(), exp_beat(b));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_nnz();
        for (int t = 0; t < 2; t++) begin
            set_desc4();
            drive_cfg((t == 0) ? 0 : 5);
            @(negedge clk);
            cfg_vld = 1'b0;
            n_checks++;
            if ({cfg_err, out_vld, busy, cfg_rdy} !== 4'b1001) begin
                n_errors++;
                $display("FAIL bad_nnz%0d_pulse: got %b expected 1001", t, {cfg_err, out_vld, busy, cfg_rdy});
            end
            @(negedge clk);
            n_checks++;
            if ({cfg_err, out_vld, busy, cfg_rdy} !== 4'b0001) begin
                n_errors++;
                $display("FAIL bad_nnz%0d_after: got %b expected 0001", t, {cfg_err, out_vld, busy, cfg_rdy});
            end
        end
    endtask

    task automatic test_reset_mid();
        m_col[0] = 3'd2; m_col[1] = 3'd6;
        m_vi[0] = 32'd11; m_vr[0] = 32'd22; m_vi[1] = 32'd33; m_vr[1] = 32'd44;
        out_rdy = 1'b1;
        drive_cfg(2);
        @(negedge clk);
        cfg_vld = 1'b0;
        for (int b = 0; b < 7; b++) @(negedge clk);
        n_checks++;
        if ({out_row, out_col, out_last_row} !== {3'd3, 3'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL rst_pos: got %b expected 0110011", {out_row, out_col, out_last_row});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_vld, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_abort: got %b expected 00", {out_vld, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cfg_rdy, out_vld} !== 2'b10) begin
            n_errors++;
            $display("FAIL rst_release: got %b expected 10", {cfg_rdy, out_vld});
        end
        m_col[0] = 3'd0; m_col[1] = 3'd3; m_col[2] = 3'd5;
        m_vi[2] = 32'd55; m_vr[2] = 32'd66;
        drive_cfg(3);
        @(negedge clk);
        cfg_vld = 1'b0;
        for (int b = 0; b < 24; b++) begin
            n_checks++;
            if (act_beat() !== exp_beat(b)) begin
                n_errors++;
                $display("FAIL rst_new_beat%0d: got %h expected %h", b, act_beat(), exp_beat(b));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_vld, cfg_rdy} !== 2'b01) begin
            n_errors++;
            $display("FAIL rst_new_end: got %b expected 01", {out_vld, cfg_rdy});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_rate();
        test_two_slot();
        test_stall();
        test_cfg_during_emit();
        test_bad_nnz();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
